memory_game_core: RTL and testbench
===================================

MEMORY_GAME_CORE -- requirements
Module: memory_game_core

Interface
REQ-001 Parameters SHALL be: ROWS, default 4, board rows; COLS, default 4, board columns (ROWS*COLS even, 4..64); SYM_W, default 4, card symbol width; PLAYERS, default 2, player count (2..4); TURN_SEC, default 15, per-turn time limit in ticks; SHOW_TICKS, default 2, mismatch display time in ticks.
REQ-002 Derived widths SHALL be: N=ROWS*COLS; IW=$clog2(N); SW=$clog2(N/2+1); PW=$clog2(PLAYERS); TW=$clog2(TURN_SEC+1).
REQ-003 clk  in  1  system clock; one clock, all logic on rising edge.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 load_en  in  1  write load_val into deck[load_addr]; honoured only in IDLE.
REQ-006 load_addr  in  IW  deck index (y*COLS+x).
REQ-007 load_val  in  SYM_W  card symbol.
REQ-008 start  in  1  single-cycle pulse, begins game from IDLE.
REQ-009 move  in  1  single-cycle pulse, advance cursor.
REQ-010 select  in  1  single-cycle pulse, pick card under cursor.
REQ-011 tick  in  1  single-cycle pulse, 1 s time base.
REQ-012 cursor_x / cursor_y  out  $clog2(COLS) / $clog2(ROWS)  cursor position.
REQ-013 revealed / matched  out  N each  per-cell face-up / removed flags.
REQ-014 player  out  PW  current player.
REQ-015 scores  out  PLAYERS*SW  packed pair counts, player 0 in LSBs.
REQ-016 time_left  out  TW  remaining ticks of current turn.
REQ-017 game_over, tie  out  1 each; winner  out  PW.

Function
REQ-018 States SHALL be IDLE, PICK1, PICK2, CHECK, SHOW, DONE.
REQ-019 IDLE: start -> PICK1, player=0, time_left=TURN_SEC; load_en/start same cycle: write occurs, transition occurs.
REQ-020 move in PICK1/PICK2/SHOW SHALL advance x+1; x=COLS-1 -> x=0, y+1; last cell -> (0,0); ignored in IDLE, CHECK, DONE.
REQ-021 select+move same cycle: select uses pre-move cursor, move also applied.
REQ-022 PICK1: select on cell not matched and not revealed -> set revealed, store index a, -> PICK2; else ignored.
REQ-023 PICK2: select on valid cell other than a -> set revealed, store index b, -> CHECK; reselecting a ignored.
REQ-024 CHECK (exactly 1 cycle): deck[a]==deck[b] -> set matched[a],[b], clear revealed, scores[player]+1, same player, time_left=TURN_SEC, -> PICK1, or DONE if all N matched.
REQ-025 CHECK mismatch -> SHOW with internal counter=SHOW_TICKS; each tick decrements; at 0 clear revealed, player=(player+1) mod PLAYERS, time_left=TURN_SEC, -> PICK1.
REQ-026 PICK1/PICK2: tick decrements time_left; tick at time_left==1 -> timeout: clear revealed, next player, time_left=TURN_SEC, -> PICK1; select in same cycle ignored.
REQ-027 time_left SHALL hold in CHECK, SHOW, IDLE, DONE.
REQ-028 DONE: game_over=1; winner = lowest-index player with max score; tie=1 if >1 player holds max; remains until rst; all pulses ignored.
REQ-029 Scores SHALL never wrap (max N/2 by construction).
REQ-030 All outputs registered; state changes visible the cycle after the triggering pulse.

Reset
REQ-031 rst SHALL force IDLE, cursor (0,0), revealed=0, matched=0, player=0, scores=0, time_left=TURN_SEC, game_over=0, tie=0, winner=0; deck contents retained.
REQ-032 rst mid-game SHALL abort immediately with the values of REQ-031; rst dominates all inputs.

Verification
REQ-033 Defaults, deck 0,0,1,1,...: start; select (0,0); move; select (1,0) -> CHECK match, matched[1:0]=11, scores[0]=1, player=0, time_left=15.
REQ-034 Select (0,0), move twice, select (2,0) (symbols 0,1) -> revealed=0x5 during SHOW; after 2 ticks revealed=0, player=1.
REQ-035 Start, 15 ticks, no select -> player=1, time_left=15, revealed=0; with PLAYERS=3, 3 timeouts -> player=0.
REQ-036 Cursor at (3,3), move -> (0,0); move+select same cycle at (0,0) -> cell 0 revealed, cursor (1,0).
REQ-037 Play all 8 pairs as player 0 -> game_over=1, winner=0, tie=0, scores[0]=8; further select/move no effect.
REQ-038 rst asserted in SHOW -> next cycle all outputs per REQ-031; start without reload replays same deck.

Source files
------------

// File: rtl/memory_game_core.sv
// Concentration-style memory game: players reveal card pairs, matches score,
// mismatches are shown briefly and pass the turn; a per-turn timer forces turn changes.
module memory_game_core #(
    parameter int unsigned ROWS       = 4,
    parameter int unsigned COLS       = 4,
    parameter int unsigned SYM_W      = 4,
    parameter int unsigned PLAYERS    = 2,
    parameter int unsigned TURN_SEC   = 15,
    parameter int unsigned SHOW_TICKS = 2,
    localparam int unsigned N  = ROWS * COLS,
    localparam int unsigned IW = $clog2(N),
    localparam int unsigned SW = $clog2(N / 2 + 1),
    localparam int unsigned PW = $clog2(PLAYERS),
    localparam int unsigned TW = $clog2(TURN_SEC + 1),
    localparam int unsigned XW = $clog2(COLS),
    localparam int unsigned YW = $clog2(ROWS)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load_en,
    input  logic [IW-1:0]         load_addr,
    input  logic [SYM_W-1:0]      load_val,
    input  logic                  start,
    input  logic                  move,
    input  logic                  select,
    input  logic                  tick,
    output logic [XW-1:0]         cursor_x,
    output logic [YW-1:0]         cursor_y,
    output logic [N-1:0]          revealed,
    output logic [N-1:0]          matched,
    output logic [PW-1:0]         player,
    output logic [PLAYERS*SW-1:0] scores,
    output logic [TW-1:0]         time_left,
    output logic                  game_over,
    output logic                  tie,
    output logic [PW-1:0]         winner
);

    localparam int unsigned CW = (SHOW_TICKS > 0) ? $clog2(SHOW_TICKS + 1) : 1;

    typedef enum logic [2:0] {StIdle, StPick1, StPick2, StCheck, StShow, StDone} state_e;

    state_e                  state_q, state_d;
    logic [XW-1:0]           x_q, x_d;
    logic [YW-1:0]           y_q, y_d;
    logic [N-1:0]            rev_q, rev_d;
    logic [N-1:0]            match_q, match_d;
    logic [PW-1:0]           player_q, player_d, player_nxt;
    logic [PLAYERS*SW-1:0]   scores_q, scores_d;
    logic [TW-1:0]           time_q, time_d;
    logic [CW-1:0]           show_q, show_d;
    logic [IW-1:0]           a_q, a_d, b_q, b_d;
    logic                    over_q, over_d, tie_q, tie_d;
    logic [PW-1:0]           win_q, win_d;
    logic [SYM_W-1:0]        deck_q [N];
    logic [IW-1:0]           cur_idx;
    logic                    cell_ok;
    logic [SW-1:0]           best;
    logic [PW-1:0]           best_idx;
    int unsigned             best_cnt;

    assign cur_idx    = IW'(int'(y_q) * COLS + int'(x_q));
    assign cell_ok    = !match_q[cur_idx] && !rev_q[cur_idx];
    assign player_nxt = (player_q == PW'(PLAYERS - 1)) ? '0 : player_q + 1'b1;

    always_comb begin
        state_d  = state_q;
        x_d      = x_q;
        y_d      = y_q;
        rev_d    = rev_q;
        match_d  = match_q;
        player_d = player_q;
        scores_d = scores_q;
        time_d   = time_q;
        show_d   = show_q;
        a_d      = a_q;
        b_d      = b_q;
        over_d   = over_q;
        tie_d    = tie_q;
        win_d    = win_q;
        best     = '0;
        best_idx = '0;
        best_cnt = 0;

        // Cursor motion is independent of any select in the same cycle (select uses cur_idx).
        if (move && (state_q == StPick1 || state_q == StPick2 || state_q == StShow)) begin
            if (x_q == XW'(COLS - 1)) begin
                x_d = '0;
                y_d = (y_q == YW'(ROWS - 1)) ? '0 : y_q + 1'b1;
            end else begin
                x_d = x_q + 1'b1;
            end
        end

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d  = StPick1;
                    player_d = '0;
                    time_d   = TW'(TURN_SEC);
                end
            end
            StPick1, StPick2: begin
                if (tick && time_q == TW'(1)) begin
                    rev_d    = '0;
                    player_d = player_nxt;
                    time_d   = TW'(TURN_SEC);
                    state_d  = StPick1;
                end else begin
                    if (tick) time_d = time_q - 1'b1;
                    if (select && cell_ok) begin
                        rev_d[cur_idx] = 1'b1;
                        if (state_q == StPick1) begin
                            a_d     = cur_idx;
                            state_d = StPick2;
                        end else begin
                            b_d     = cur_idx;
                            state_d = StCheck;
                        end
                    end
                end
            end
            StCheck: begin
                if (deck_q[a_q] == deck_q[b_q]) begin
                    match_d[a_q] = 1'b1;
                    match_d[b_q] = 1'b1;
                    rev_d        = '0;
                    scores_d[int'(player_q)*SW +: SW] = scores_q[int'(player_q)*SW +: SW] + 1'b1;
                    time_d       = TW'(TURN_SEC);
                    state_d      = (&match_d) ? StDone : StPick1;
                end else begin
                    show_d  = CW'(SHOW_TICKS);
                    state_d = StShow;
                end
            end
            StShow: begin
                if (show_q == '0 || (tick && show_q == CW'(1))) begin
                    rev_d    = '0;
                    player_d = player_nxt;
                    time_d   = TW'(TURN_SEC);
                    state_d  = StPick1;
                end else if (tick) begin
                    show_d = show_q - 1'b1;
                end
            end
            StDone: ;
            default: state_d = StIdle;
        endcase

        // Lowest index wins ties for the maximum thanks to the strict comparison.
        for (int i = 0; i < PLAYERS; i++) begin
            if (scores_d[i*SW +: SW] > best) begin
                best     = scores_d[i*SW +: SW];
                best_idx = PW'(i);
            end
        end
        for (int i = 0; i < PLAYERS; i++) begin
            if (scores_d[i*SW +: SW] == best) best_cnt = best_cnt + 1;
        end
        if (state_d == StDone) begin
            over_d = 1'b1;
            win_d  = best_idx;
            tie_d  = (best_cnt > 1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            x_q      <= '0;
            y_q      <= '0;
            rev_q    <= '0;
            match_q  <= '0;
            player_q <= '0;
            scores_q <= '0;
            time_q   <= TW'(TURN_SEC);
            show_q   <= '0;
            a_q      <= '0;
            b_q      <= '0;
            over_q   <= 1'b0;
            tie_q    <= 1'b0;
            win_q    <= '0;
        end else begin
            state_q  <= state_d;
            x_q      <= x_d;
            y_q      <= y_d;
            rev_q    <= rev_d;
            match_q  <= match_d;
            player_q <= player_d;
            scores_q <= scores_d;
            time_q   <= time_d;
            show_q   <= show_d;
            a_q      <= a_d;
            b_q      <= b_d;
            over_q   <= over_d;
            tie_q    <= tie_d;
            win_q    <= win_d;
        end
    end

    // Deck survives reset so a game can be replayed without reloading.
    always_ff @(posedge clk) begin
        if (!rst && load_en && state_q == StIdle && int'(load_addr) < N) begin
            deck_q[load_addr] <= load_val;
        end
    end

    assign cursor_x  = x_q;
    assign cursor_y  = y_q;
    assign revealed  = rev_q;
    assign matched   = match_q;
    assign player    = player_q;
    assign scores    = scores_q;
    assign time_left = time_q;
    assign game_over = over_q;
    assign tie       = tie_q;
    assign winner    = win_q;

endmodule

// File: tb/tb_memory_game_core.sv
// Directed bench for memory_game_core: a 2-player and a 3-player instance share stimulus.
module tb_memory_game_core;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        load_en = 1'b0;
    logic [3:0]  load_addr = '0;
    logic [3:0]  load_val = '0;
    logic        start = 1'b0;
    logic        move = 1'b0;
    logic        select = 1'b0;
    logic        tick = 1'b0;

    logic [1:0]  cursor_x, cursor_y;
    logic [15:0] revealed, matched;
    logic [0:0]  player, winner;
    logic [7:0]  scores;
    logic [3:0]  time_left;
    logic        game_over, tie;

    logic [1:0]  cursor_x3, cursor_y3;
    logic [15:0] revealed3, matched3;
    logic [1:0]  player3, winner3;
    logic [11:0] scores3;
    logic [3:0]  time_left3;
    logic        game_over3, tie3;

    int checks = 0;
    int fails  = 0;

    always #5 clk = ~clk;

    memory_game_core dut (
        .clk(clk), .rst(rst), .load_en(load_en), .load_addr(load_addr), .load_val(load_val),
        .start(start), .move(move), .select(select), .tick(tick),
        .cursor_x(cursor_x), .cursor_y(cursor_y), .revealed(revealed), .matched(matched),
        .player(player), .scores(scores), .time_left(time_left), .game_over(game_over),
        .tie(tie), .winner(winner)
    );

    memory_game_core #(.PLAYERS(3)) dut3 (
        .clk(clk), .rst(rst), .load_en(load_en), .load_addr(load_addr), .load_val(load_val),
        .start(start), .move(move), .select(select), .tick(tick),
        .cursor_x(cursor_x3), .cursor_y(cursor_y3), .revealed(revealed3), .matched(matched3),
        .player(player3), .scores(scores3), .time_left(time_left3), .game_over(game_over3),
        .tie(tie3), .winner(winner3)
    );

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; cyc(); rst = 1'b0;
    endtask
    task automatic do_start();
        start = 1'b1; cyc(); start = 1'b0;
    endtask
    task automatic do_move();
        move = 1'b1; cyc(); move = 1'b0;
    endtask
    task automatic do_sel();
        select = 1'b1; cyc(); select = 1'b0;
    endtask
    task automatic do_tick();
        tick = 1'b1; cyc(); tick = 1'b0;
    endtask

    task automatic load_deck();
        for (int i = 0; i < 16; i++) begin
            load_en = 1'b1; load_addr = 4'(i); load_val = 4'(i / 2);
            cyc();
        end
        load_en = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if ({cursor_y, cursor_x} !== 4'h0) begin fails++;
            $display("FAIL reset_cursor: got %h want 0", {cursor_y, cursor_x}); end
        checks++; if (revealed !== 16'h0 || matched !== 16'h0) begin fails++;
            $display("FAIL reset_flags: got rev=%h mat=%h want 0/0", revealed, matched); end
        checks++; if (player !== 1'b0 || scores !== 8'h0) begin fails++;
            $display("FAIL reset_player_scores: got p=%0d s=%h want 0/0", player, scores); end
        checks++; if (time_left !== 4'd15) begin fails++;
            $display("FAIL reset_time: got %0d want 15", time_left); end
        checks++; if (game_over !== 1'b0 || tie !== 1'b0 || winner !== 1'b0) begin fails++;
            $display("FAIL reset_done_flags: got %b%b%b want 000", game_over, tie, winner); end
    endtask

    task automatic test_match();
        do_reset();
        do_start();
        checks++; if (time_left !== 4'd15 || player !== 1'b0) begin fails++;
            $display("FAIL start_state: got t=%0d p=%0d want 15/0", time_left, player); end
        do_sel();
        checks++; if (revealed !== 16'h0001) begin fails++;
            $display("FAIL first_pick: got %h want 0001", revealed); end
        do_move();
        do_sel();
        checks++; if (revealed !== 16'h0003) begin fails++;
            $display("FAIL second_pick: got %h want 0003", revealed); end
        cyc();
        checks++; if (matched !== 16'h0003 || revealed !== 16'h0) begin fails++;
            $display("FAIL match_flags: got mat=%h rev=%h want 0003/0", matched, revealed); end
        checks++; if (scores[3:0] !== 4'd1 || player !== 1'b0 || time_left !== 4'd15) begin
            fails++;
            $display("FAIL match_score: got s0=%0d p=%0d t=%0d want 1/0/15",
                     scores[3:0], player, time_left); end
    endtask

    task automatic test_mismatch();
        do_reset();
        do_start();
        do_sel();
        do_move();
        do_move();
        do_sel();
        cyc();
        checks++; if (revealed !== 16'h0005 || player !== 1'b0) begin fails++;
            $display("FAIL show_reveal: got rev=%h p=%0d want 0005/0", revealed, player); end
        do_tick();
        checks++; if (revealed !== 16'h0005 || time_left !== 4'd15) begin fails++;
            $display("FAIL show_one_tick: got rev=%h t=%0d want 0005/15", revealed, time_left); end
        do_tick();
        checks++; if (revealed !== 16'h0 || player !== 1'b1 || matched !== 16'h0) begin fails++;
            $display("FAIL show_end: got rev=%h p=%0d mat=%h want 0/1/0",
                     revealed, player, matched); end
        checks++; if (scores !== 8'h0 || time_left !== 4'd15) begin fails++;
            $display("FAIL show_end_score: got s=%h t=%0d want 0/15", scores, time_left); end
    endtask

    task automatic test_timeout();
        do_reset();
        do_start();
        do_sel();
        do_move();
        for (int i = 0; i < 14; i++) do_tick();
        checks++; if (time_left !== 4'd1 || player !== 1'b0 || revealed !== 16'h0001) begin
            fails++;
            $display("FAIL timer_count: got t=%0d p=%0d rev=%h want 1/0/0001",
                     time_left, player, revealed); end
        tick = 1'b1; select = 1'b1; cyc(); tick = 1'b0; select = 1'b0;
        checks++; if (revealed !== 16'h0 || player !== 1'b1 || time_left !== 4'd15) begin
            fails++;
            $display("FAIL timeout: got rev=%h p=%0d t=%0d want 0/1/15",
                     revealed, player, time_left); end
        checks++; if (player3 !== 2'd1) begin fails++;
            $display("FAIL timeout_p3_1: got %0d want 1", player3); end
        for (int i = 0; i < 15; i++) do_tick();
        checks++; if (player3 !== 2'd2 || player !== 1'b0) begin fails++;
            $display("FAIL timeout_2: got p3=%0d p=%0d want 2/0", player3, player); end
        for (int i = 0; i < 15; i++) do_tick();
        checks++; if (player3 !== 2'd0 || player !== 1'b1 || time_left3 !== 4'd15) begin fails++;
            $display("FAIL timeout_3: got p3=%0d p=%0d t3=%0d want 0/1/15",
                     player3, player, time_left3); end
    endtask

    task automatic test_cursor_wrap();
        do_reset();
        do_move();
        checks++; if ({cursor_y, cursor_x} !== 4'h0) begin fails++;
            $display("FAIL move_in_idle: got %h want 0", {cursor_y, cursor_x}); end
        do_start();
        for (int i = 0; i < 15; i++) do_move();
        checks++; if (cursor_x !== 2'd3 || cursor_y !== 2'd3) begin fails++;
            $display("FAIL cursor_last: got (%0d,%0d) want (3,3)", cursor_x, cursor_y); end
        do_move();
        checks++; if (cursor_x !== 2'd0 || cursor_y !== 2'd0) begin fails++;
            $display("FAIL cursor_wrap: got (%0d,%0d) want (0,0)", cursor_x, cursor_y); end
        move = 1'b1; select = 1'b1; cyc(); move = 1'b0; select = 1'b0;
        checks++; if (revealed !== 16'h0001 || cursor_x !== 2'd1 || cursor_y !== 2'd0) begin
            fails++;
            $display("FAIL move_select: got rev=%h (%0d,%0d) want 0001 (1,0)",
                     revealed, cursor_x, cursor_y); end
    endtask

    task automatic test_full_game();
        do_reset();
        do_start();
        for (int p = 0; p < 8; p++) begin
            do_sel();
            do_move();
            do_sel();
            cyc();
            do_move();
        end
        checks++; if (game_over !== 1'b1 || winner !== 1'b0 || tie !== 1'b0) begin fails++;
            $display("FAIL game_over: got go=%b w=%0d tie=%b want 1/0/0", game_over, winner, tie);
        end
        checks++; if (scores !== 8'h08 || matched !== 16'hffff) begin fails++;
            $display("FAIL final_score: got s=%h mat=%h want 08/ffff", scores, matched); end
        checks++; if (cursor_x !== 2'd3 || cursor_y !== 2'd3) begin fails++;
            $display("FAIL done_cursor: got (%0d,%0d) want (3,3)", cursor_x, cursor_y); end
        do_move();
        do_sel();
        do_tick();
        do_start();
        checks++; if (cursor_x !== 2'd3 || revealed !== 16'h0 || game_over !== 1'b1
                      || time_left !== 4'd15 || scores !== 8'h08) begin fails++;
            $display("FAIL done_frozen: got x=%0d rev=%h go=%b t=%0d s=%h want 3/0/1/15/08",
                     cursor_x, revealed, game_over, time_left, scores); end
    endtask

    task automatic test_reset_in_show();
        do_reset();
        do_start();
        do_sel();
        do_move();
        do_move();
        do_sel();
        cyc();
        do_reset();
        checks++; if (revealed !== 16'h0 || matched !== 16'h0 || {cursor_y, cursor_x} !== 4'h0)
        begin fails++;
            $display("FAIL rst_show_flags: got rev=%h mat=%h cur=%h want 0/0/0",
                     revealed, matched, {cursor_y, cursor_x}); end
        checks++; if (player !== 1'b0 || time_left !== 4'd15 || game_over !== 1'b0) begin fails++;
            $display("FAIL rst_show_state: got p=%0d t=%0d go=%b want 0/15/0",
                     player, time_left, game_over); end
        do_start();
        // A load outside IDLE must not corrupt the retained deck.
        load_en = 1'b1; load_addr = 4'd1; load_val = 4'd9; cyc(); load_en = 1'b0;
        do_sel();
        do_move();
        do_sel();
        cyc();
        checks++; if (matched !== 16'h0003 || scores[3:0] !== 4'd1) begin fails++;
            $display("FAIL replay_match: got mat=%h s0=%0d want 0003/1", matched, scores[3:0]); end
    endtask

    initial begin
        do_reset();
        load_deck();
        test_reset();
        test_match();
        test_mismatch();
        test_timeout();
        test_cursor_wrap();
        test_full_game();
        test_reset_in_show();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
